// File: rtl/aemb2_xwb_gpio.sv
// Wishbone GPIO responder: OUT, DIR, synchronised IN and edge STAT/MASK registers for 8 pins,
// with a registered level interrupt built from unmasked rising-edge status bits.
module aemb2_xwb_gpio #(
    parameter int          AW      = 4,
    parameter logic [7:0]  RST_DIR = 8'h00
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic [AW-1:2] xwb_adr_o,
    input  logic [31:0]   xwb_dat_o,
    input  logic [3:0]    xwb_sel_o,
    input  logic          xwb_stb_o,
    input  logic          xwb_cyc_o,
    input  logic          xwb_wre_o,
    input  logic          xwb_tag_o,
    output logic [31:0]   xwb_dat_i,
    output logic          xwb_ack_i,
    inout  wire  [7:0]    gpio,
    output logic          sys_int_o
);

    logic        req;
    logic        access;
    logic        wr_en;
    logic [1:0]  reg_sel;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_dir;
    logic [7:0]  gpio_stat;
    logic [7:0]  gpio_mask;
    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  prev;
    logic [7:0]  rise;
    logic [7:0]  stat_clr;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign unused_bits = ^{xwb_tag_o, xwb_dat_o[31:16], xwb_sel_o[3:2], xwb_adr_o};

    // A transfer is serviced only on the first cycle of a request; the ack cycle itself is idle.
    assign req     = xwb_cyc_o & xwb_stb_o;
    assign access  = req & ~xwb_ack_i;
    assign wr_en   = access & xwb_wre_o;
    assign reg_sel = xwb_adr_o[3:2];

    assign rise     = sync2 & ~prev;
    assign stat_clr = (wr_en && reg_sel == 2'd3 && xwb_sel_o[0]) ? xwb_dat_o[7:0] : 8'h00;

    always_comb begin
        rd_data = 32'h0;
        case (reg_sel)
            2'd0: rd_data = {24'h0, gpio_out};
            2'd1: rd_data = {24'h0, gpio_dir};
            2'd2: rd_data = {24'h0, sync2};
            2'd3: rd_data = {16'h0, gpio_mask, gpio_stat};
            default: rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            gpio_out  <= 8'h00;
            gpio_dir  <= RST_DIR;
            gpio_stat <= 8'h00;
            gpio_mask <= 8'h00;
            sync1     <= 8'h00;
            sync2     <= 8'h00;
            prev      <= 8'h00;
            xwb_ack_i <= 1'b0;
            xwb_dat_i <= 32'h0;
            sys_int_o <= 1'b0;
        end else begin
            xwb_ack_i <= access;
            xwb_dat_i <= access ? rd_data : 32'h0;
            sync1     <= gpio;
            sync2     <= sync1;
            prev      <= sync2;
            // A new edge in the same cycle as a clear keeps the bit set.
            gpio_stat <= (gpio_stat & ~stat_clr) | rise;
            sys_int_o <= |(gpio_stat & gpio_mask);
            if (wr_en && xwb_sel_o[0]) begin
                case (reg_sel)
                    2'd0:    gpio_out <= xwb_dat_o[7:0];
                    2'd1:    gpio_dir <= xwb_dat_o[7:0];
                    default: ;
                endcase
            end
            if (wr_en && reg_sel == 2'd3 && xwb_sel_o[1]) begin
                gpio_mask <= xwb_dat_o[15:8];
            end
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_pin
        assign gpio[i] = gpio_dir[i] ? gpio_out[i] : 1'bz;
    end

endmodule

// File: tb/tb_aemb2_xwb_gpio.sv
// Directed, table-driven bench for aemb2_xwb_gpio: register map, byte lanes, handshake,
// edge status, interrupt, set-vs-clear priority and reset during a transfer.
module tb_aemb2_xwb_gpio;

    logic        sys_clk_i;
    logic        sys_rst_i;
    logic [3:2]  xwb_adr_o;
    logic [31:0] xwb_dat_o;
    logic [3:0]  xwb_sel_o;
    logic        xwb_stb_o;
    logic        xwb_cyc_o;
    logic        xwb_wre_o;
    logic        xwb_tag_o;
    logic [31:0] xwb_dat_i;
    logic        xwb_ack_i;
    wire  [7:0]  gpio;
    logic        sys_int_o;

    logic [7:0]  tbDrive;
    logic [7:0]  tbEn;
    int          checks;
    int          errors;

    typedef struct {
        bit          wr;
        logic [1:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] expRd;
        bit          chkGpio;
        logic [7:0]  expGpio;
    } vec_t;

    vec_t vecs[$];

    aemb2_xwb_gpio #(.AW(4), .RST_DIR(8'h00)) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .xwb_adr_o (xwb_adr_o),
        .xwb_dat_o (xwb_dat_o),
        .xwb_sel_o (xwb_sel_o),
        .xwb_stb_o (xwb_stb_o),
        .xwb_cyc_o (xwb_cyc_o),
        .xwb_wre_o (xwb_wre_o),
        .xwb_tag_o (xwb_tag_o),
        .xwb_dat_i (xwb_dat_i),
        .xwb_ack_i (xwb_ack_i),
        .gpio      (gpio),
        .sys_int_o (sys_int_o)
    );

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign gpio[i] = tbEn[i] ? tbDrive[i] : 1'bz;
    end

    initial begin
        sys_clk_i = 1'b0;
        forever #5 sys_clk_i = ~sys_clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    task automatic busIdle();
        xwb_cyc_o = 1'b0;
        xwb_stb_o = 1'b0;
        xwb_wre_o = 1'b0;
        xwb_sel_o = 4'h0;
        xwb_adr_o = 2'd0;
        xwb_dat_o = 32'h0;
    endtask

    // One single-beat transfer; returns ack before and after the first edge plus the read data.
    task automatic busXfer(input bit wr, input logic [1:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic ackEarly, output logic ackSeen,
                           output logic [31:0] rd);
        @(negedge sys_clk_i);
        xwb_cyc_o = 1'b1;
        xwb_stb_o = 1'b1;
        xwb_wre_o = wr;
        xwb_adr_o = adr;
        xwb_dat_o = wdat;
        xwb_sel_o = sel;
        ackEarly  = xwb_ack_i;
        @(posedge sys_clk_i);
        #1;
        ackSeen = xwb_ack_i;
        rd      = xwb_dat_i;
        @(negedge sys_clk_i);
        busIdle();
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic        ackEarly;
        logic        ackSeen;
        logic [31:0] rd;
        busXfer(v.wr, v.adr, v.wdat, v.sel, ackEarly, ackSeen, rd);
        checkOutput($sformatf("vec%0d_ack_early", idx), {31'h0, ackEarly}, 32'h0);
        checkOutput($sformatf("vec%0d_ack", idx), {31'h0, ackSeen}, 32'h1);
        if (!v.wr) checkOutput($sformatf("vec%0d_rdata", idx), rd, v.expRd);
        if (v.chkGpio) checkOutput($sformatf("vec%0d_gpio", idx), {24'h0, gpio}, {24'h0, v.expGpio});
    endtask

    task automatic readExpect(input string name, input logic [1:0] adr, input logic [31:0] exp);
        logic        ackEarly;
        logic        ackSeen;
        logic [31:0] rd;
        busXfer(1'b0, adr, 32'h0, 4'hF, ackEarly, ackSeen, rd);
        checkOutput({name, "_ack"}, {31'h0, ackSeen}, 32'h1);
        checkOutput(name, rd, exp);
    endtask

    task automatic writeReg(input string name, input logic [1:0] adr, input logic [31:0] wdat,
                            input logic [3:0] sel);
        logic        ackEarly;
        logic        ackSeen;
        logic [31:0] rd;
        busXfer(1'b1, adr, wdat, sel, ackEarly, ackSeen, rd);
        checkOutput({name, "_ack"}, {31'h0, ackSeen}, 32'h1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        tbDrive   = 8'h00;
        tbEn      = 8'h00;
        xwb_tag_o = 1'b0;
        busIdle();
        sys_rst_i = 1'b1;

        //           wr    adr   wdat          sel    expRd         chkGpio expGpio
        vecs.push_back('{1'b0, 2'd0, 32'h0,        4'hF,  32'h0000_0000, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'd1, 32'h0,        4'hF,  32'h0000_0000, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'd3, 32'h0,        4'hF,  32'h0000_0000, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'd0, 32'h0000_00A5, 4'h1, 32'h0,         1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'd1, 32'h0000_00FF, 4'h1, 32'h0,         1'b1, 8'hA5});
        vecs.push_back('{1'b1, 2'd0, 32'h0000_003C, 4'h2, 32'h0,         1'b1, 8'hA5});
        vecs.push_back('{1'b0, 2'd0, 32'h0,        4'hF,  32'h0000_00A5, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'd2, 32'h0,        4'hF,  32'h0000_00A5, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'd2, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'd2, 32'h0,        4'hF,  32'h0000_00A5, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'd1, 32'h0,        4'hF,  32'h0000_00FF, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'd3, 32'h0,        4'hF,  32'h0000_00A5, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'd3, 32'h0000_00FF, 4'h1, 32'h0,         1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'd3, 32'h0,        4'hF,  32'h0000_0000, 1'b0, 8'h00});

        repeat (3) @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        checkOutput("reset_ack", {31'h0, xwb_ack_i}, 32'h0);
        checkOutput("reset_dat", xwb_dat_i, 32'h0);
        checkOutput("reset_int", {31'h0, sys_int_o}, 32'h0);

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Continuous read strobe: ack alternates, data only during ack.
        @(negedge sys_clk_i);
        xwb_cyc_o = 1'b1;
        xwb_stb_o = 1'b1;
        xwb_wre_o = 1'b0;
        xwb_adr_o = 2'd1;
        xwb_sel_o = 4'hF;
        checkOutput("b2b_ack0", {31'h0, xwb_ack_i}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge sys_clk_i);
            #1;
            checkOutput($sformatf("b2b_ack%0d", k + 1), {31'h0, xwb_ack_i}, (k % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("b2b_dat%0d", k + 1), xwb_dat_i, (k % 2 == 0) ? 32'hFF : 32'h0);
        end
        @(negedge sys_clk_i);
        busIdle();

        // Rising edge on pin 0 with MASK bit 0 set.
        writeReg("dir_in", 2'd1, 32'h0, 4'h1);
        tbDrive = 8'h00;
        tbEn    = 8'hFF;
        writeReg("mask_set", 2'd3, 32'h0000_01FF, 4'h3);
        repeat (3) @(posedge sys_clk_i);
        #1;
        checkOutput("int_idle", {31'h0, sys_int_o}, 32'h0);
        @(negedge sys_clk_i);
        tbDrive = 8'h01;
        repeat (3) @(posedge sys_clk_i);
        #1;
        checkOutput("int_not_yet", {31'h0, sys_int_o}, 32'h0);
        @(posedge sys_clk_i);
        #1;
        checkOutput("int_raised", {31'h0, sys_int_o}, 32'h1);
        readExpect("stat_set", 2'd3, 32'h0000_0101);
        writeReg("stat_w1c", 2'd3, 32'h0000_0101, 4'h3);
        @(posedge sys_clk_i);
        #1;
        checkOutput("int_dropped", {31'h0, sys_int_o}, 32'h0);
        readExpect("stat_cleared", 2'd3, 32'h0000_0100);

        // Rising edge on pin 1 lands in the same cycle as the W1C of bit 1.
        @(negedge sys_clk_i);
        tbDrive = 8'h03;
        @(posedge sys_clk_i);
        @(posedge sys_clk_i);
        writeReg("w1c_race", 2'd3, 32'h0000_0002, 4'h1);
        readExpect("set_wins", 2'd3, 32'h0000_0102);
        checkOutput("race_int", {31'h0, sys_int_o}, 32'h0);

        // Reset asserted on the first cycle of a write.
        tbDrive = 8'h00;
        repeat (4) @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        xwb_cyc_o = 1'b1;
        xwb_stb_o = 1'b1;
        xwb_wre_o = 1'b1;
        xwb_adr_o = 2'd0;
        xwb_dat_o = 32'h0000_005A;
        xwb_sel_o = 4'h1;
        sys_rst_i = 1'b1;
        @(posedge sys_clk_i);
        #1;
        checkOutput("rst_xfer_ack", {31'h0, xwb_ack_i}, 32'h0);
        checkOutput("rst_xfer_dat", xwb_dat_i, 32'h0);
        checkOutput("rst_xfer_int", {31'h0, sys_int_o}, 32'h0);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        busIdle();
        readExpect("rst_out", 2'd0, 32'h0);
        readExpect("rst_dir", 2'd1, 32'h0);
        readExpect("rst_stat", 2'd3, 32'h0);
        tbDrive = 8'h3C;
        repeat (4) @(posedge sys_clk_i);
        readExpect("pins_released", 2'd2, 32'h0000_003C);
        readExpect("stat_after_rst", 2'd3, 32'h0000_003C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
